// File: rtl/reg_serializer.sv
// -----------------------------------------------------------------------------
// reg_serializer
//
// Purpose:
//    Parallel-in / serial-out transmit register. A LEN-bit word is captured
//    from the register-file side on an accepted load_s and shifted out one bit
//    per clk_enable tick. A ready/busy/done handshake paces the producer.
//
// Parameters:
//    LEN         word width in bits (>= 2)
//    MSB_FIRST   1: bit LEN-1 leaves first, 0: bit 0 leaves first
//    IDLE_LEVEL  level driven on sout whenever no word is in flight
//
// Ports:
//    clk         rising-edge clock
//    clr         asynchronous reset, active-high
//    clr_s       synchronous clear, active-low (not gated by clk_enable)
//    data        word to transmit, sampled on the accepting edge
//    load_s      start request, honoured only while ready=1
//    clk_enable  bit-rate tick, one bit advances per high cycle
//    sout        registered serial data out
//    ready       idle, a load_s is accepted on this edge
//    busy        word in flight
//    done        single-cycle pulse after the last bit's tick
// -----------------------------------------------------------------------------
module reg_serializer #(
   parameter int   LEN        = 8,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic           clk,
   input  logic           clr,
   input  logic           clr_s,
   input  logic [LEN-1:0] data,
   input  logic           load_s,
   input  logic           clk_enable,
   output logic           sout,
   output logic           ready,
   output logic           busy,
   output logic           done
);

   localparam int CW = $clog2(LEN);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [1:0]     state_q, state_d;
   logic [LEN-1:0] shreg_q, shreg_d;
   logic [LEN-1:0] shreg_shifted;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           sout_q, sout_d;

   // Shift one place toward the output end, zero-filling the far end.
   genvar gi;
   generate
      for (gi = 0; gi < LEN; gi++) begin : g_shift
         if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_fill
               assign shreg_shifted[gi] = 1'b0;
            end else begin : g_move
               assign shreg_shifted[gi] = shreg_q[gi-1];
            end
         end else begin : g_lsb
            if (gi == LEN - 1) begin : g_fill
               assign shreg_shifted[gi] = 1'b0;
            end else begin : g_move
               assign shreg_shifted[gi] = shreg_q[gi+1];
            end
         end
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;

      if (!clr_s) begin
         // Synchronous clear beats any pending load or shift.
         state_d = S_IDLE;
         shreg_d = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load_s) begin
                  shreg_d = data;
                  cnt_d   = CNT_LAST;
                  state_d = S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (clk_enable) begin
                  if (cnt_q == '0) begin
                     state_d = S_DONE;
                  end else begin
                     shreg_d = shreg_shifted;
                     cnt_d   = cnt_q - CNT_ONE;
                  end
               end
            end
            S_DONE: begin
               // load_s deliberately ignored here; no request is queued.
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // sout is registered, so it is computed from the next state/shreg:
      // the first bit then appears in the cycle after the load edge.
      if (state_d == S_SHIFT) begin
         sout_d = MSB_FIRST ? shreg_d[LEN-1] : shreg_d[0];
      end else begin
         sout_d = IDLE_LEVEL;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         sout_q  <= IDLE_LEVEL;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         sout_q  <= sout_d;
      end
   end

   assign sout  = sout_q;
   assign ready = (state_q == S_IDLE);
   assign busy  = (state_q == S_SHIFT);
   assign done  = (state_q == S_DONE);

endmodule
